// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the wait-state memory responder.
// Holds the FSM state encoding, the latched operation encoding and the
// helper that sizes the wait-state counter.
package mem_resp_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   // Counter width able to hold 0..limit, never narrower than one bit so
   // that a zero-wait build still elaborates a legal vector.
   function automatic int cnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state counter for the memory responder.
// Loaded to 1 when a request is accepted, advanced once per wait cycle,
// and flags terminal when the count has reached LIMIT.
module mem_wait_counter #(
   parameter int LIMIT = 2,
   parameter int W     = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic enable,
   output logic terminal
);

   localparam logic [W-1:0] LAST = W'(LIMIT);

   logic [W-1:0] count;

   // Count register: load restarts at 1, enable steps by one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= W'(1);
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign terminal = (count == LAST);

endmodule

// File: rtl/mem_wait_responder.sv
// Word-organised RAM responder with programmable wait states and a
// one-cycle mem_ready completion pulse.
// Optional feature macro: MEM_MISALIGN_ERR_EN adds mem_err and turns
// misaligned accesses into error responses with the write suppressed.
module mem_wait_responder
   import mem_resp_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WORD_W-1:0] mem_adr,
   input  logic [WORD_W-1:0] mem_in,
   input  logic              mem_read,
   input  logic              mem_write,
   output logic [WORD_W-1:0] mem_out,
   output logic              mem_ready
`ifdef MEM_MISALIGN_ERR_EN
   ,
   output logic              mem_err
`endif
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int CW    = cnt_width(WAIT_CYCLES);

   state_t              state;
   state_t              next_state;
   op_t                 op_q;
   logic [ADDR_W-1:0]   idx_q;
   logic [WORD_W-1:0]   data_q;
   logic                err_q;
   logic                accept;
   logic                cnt_enable;
   logic                cnt_terminal;
   logic                misaligned;
   logic                unused_addr_bits;

   logic [WORD_W-1:0]   ram [0:DEPTH-1];

`ifdef MEM_MISALIGN_ERR_EN
   assign misaligned = |mem_adr[1:0];
`else
   assign misaligned = 1'b0;
`endif

   assign unused_addr_bits = ^{mem_adr[WORD_W-1:ADDR_W+2], mem_adr[1:0]};

   mem_wait_counter #(
      .LIMIT (WAIT_CYCLES),
      .W     (CW)
   ) u_wait_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (accept),
      .enable   (cnt_enable),
      .terminal (cnt_terminal)
   );

   // State register; reset aborts any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; IDLE always lasts at least one cycle after RESP.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      cnt_enable = 1'b0;
      case (state)
         S_IDLE: begin
            if (mem_read || mem_write) begin
               accept     = 1'b1;
               next_state = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_terminal) begin
               next_state = S_RESP;
            end else begin
               cnt_enable = 1'b1;
            end
         end
         S_RESP: begin
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Request capture at accept; a write request wins over a read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= OP_RD;
         idx_q  <= '0;
         data_q <= '0;
         err_q  <= 1'b0;
      end else if (accept) begin
         op_q   <= mem_write ? OP_WR : OP_RD;
         idx_q  <= mem_adr[ADDR_W+1:2];
         data_q <= mem_in;
         err_q  <= misaligned;
      end
   end

   // RAM commit on the edge leaving RESP so an aborted transaction never writes.
   always_ff @(posedge clk) begin
      if (state == S_RESP && op_q == OP_WR && !err_q) begin
         ram[idx_q] <= data_q;
      end
   end

   // Response outputs: data only for a clean read, zero in every other cycle.
   always_comb begin
      mem_ready = (state == S_RESP);
      mem_out   = '0;
      if (state == S_RESP && op_q == OP_RD && !err_q) begin
         mem_out = ram[idx_q];
      end
   end

`ifdef MEM_MISALIGN_ERR_EN
   assign mem_err = (state == S_RESP) && err_q;
`endif

endmodule

// File: tb/tb_mem_wait_responder.sv
// Scoreboard bench for mem_wait_responder.
// Instance a uses WAIT_CYCLES=2, instance b uses WAIT_CYCLES=0.
// Build with MEM_MISALIGN_ERR_EN defined to also cover the error response.
module tb_mem_wait_responder;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst_n_a;
   logic        rst_n_b;
   logic [31:0] adr_a, in_a, out_a;
   logic        rd_a, wr_a, ready_a, err_a;
   logic [31:0] adr_b, in_b, out_b;
   logic        rd_b, wr_b, ready_b, err_b;

   int   checks_total;
   int   checks_passed;
   exp_t exp_q[$];

   mem_wait_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut_a (
      .clk       (clk),
      .rst_n     (rst_n_a),
      .mem_adr   (adr_a),
      .mem_in    (in_a),
      .mem_read  (rd_a),
      .mem_write (wr_a),
      .mem_out   (out_a),
      .mem_ready (ready_a)
`ifdef MEM_MISALIGN_ERR_EN
      ,
      .mem_err   (err_a)
`endif
   );

   mem_wait_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n_b),
      .mem_adr   (adr_b),
      .mem_in    (in_b),
      .mem_read  (rd_b),
      .mem_write (wr_b),
      .mem_out   (out_b),
      .mem_ready (ready_b)
`ifdef MEM_MISALIGN_ERR_EN
      ,
      .mem_err   (err_b)
`endif
   );

`ifndef MEM_MISALIGN_ERR_EN
   assign err_a = 1'b0;
   assign err_b = 1'b0;
`endif

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something stalls beyond every bounded wait.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act === exp) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   // Monitor for instance a: pops one expectation per ready pulse, and
   // requires silent outputs in every other cycle.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n_a) begin
         if (ready_a) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_ready", 32'(ready_a), 32'd0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("resp_data", out_a, e.data);
`ifdef MEM_MISALIGN_ERR_EN
               checkOutput("resp_err", 32'(err_a), 32'(e.err));
`endif
            end
         end else begin
            checkOutput("idle_out_zero", out_a, 32'd0);
`ifdef MEM_MISALIGN_ERR_EN
            checkOutput("idle_err_zero", 32'(err_a), 32'd0);
`endif
         end
      end
   end

   // One complete transaction on instance a with its expected response.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] adr,
                                input logic [31:0] data, input logic [31:0] exp_data,
                                input logic exp_err);
      int   cycles;
      exp_t e;
      e.data = exp_data;
      e.err  = exp_err;
      exp_q.push_back(e);
      rd_a  = rd;
      wr_a  = wr;
      adr_a = adr;
      in_a  = data;
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!ready_a && cycles < 40);
      checkOutput("latency_a", 32'(cycles), 32'd3);
      rd_a = 1'b0;
      wr_a = 1'b0;
      @(negedge clk);
   endtask

   // Write aborted by reset while the responder is in its wait phase.
   task automatic abortWriteInWait(input logic [31:0] adr, input logic [31:0] data);
      wr_a  = 1'b1;
      adr_a = adr;
      in_a  = data;
      @(negedge clk);
      checkOutput("wait_ready_low", 32'(ready_a), 32'd0);
      #2 rst_n_a = 1'b0;
      #1;
      checkOutput("abort_ready_low", 32'(ready_a), 32'd0);
      checkOutput("abort_out_zero", out_a, 32'd0);
      wr_a = 1'b0;
      @(negedge clk);
      rst_n_a = 1'b1;
      @(negedge clk);
   endtask

   // Read whose response cycle is cut short by reset; outputs must drop at once.
   task automatic readThenReset(input logic [31:0] adr, input logic [31:0] exp_data);
      int   cycles;
      exp_t e;
      e.data = exp_data;
      e.err  = 1'b0;
      exp_q.push_back(e);
      rd_a  = 1'b1;
      adr_a = adr;
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!ready_a && cycles < 40);
      checkOutput("latency_a", 32'(cycles), 32'd3);
      #1 rst_n_a = 1'b0;
      #1;
      checkOutput("async_ready_low", 32'(ready_a), 32'd0);
      checkOutput("async_out_zero", out_a, 32'd0);
      rd_a = 1'b0;
      @(negedge clk);
      rst_n_a = 1'b1;
      @(negedge clk);
   endtask

   // Zero-wait instance: preload a word, then hold a read and check the pulse train.
   task automatic holdReadZeroWait();
      int   cycles;
      logic prev;
      logic sample;
      wr_b  = 1'b1;
      adr_b = 32'h4;
      in_b  = 32'hCAFE0004;
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (!ready_b && cycles < 40);
      checkOutput("latency_b", 32'(cycles), 32'd1);
      checkOutput("write_out_b", out_b, 32'd0);
      wr_b = 1'b0;
      @(negedge clk);
      rd_b = 1'b1;
      prev = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         sample = ready_b;
         checkOutput("pulse_pattern_b", 32'(sample), 32'(i % 2));
         if (sample) begin
            checkOutput("read_data_b", out_b, 32'hCAFE0004);
            checkOutput("no_double_pulse_b", 32'(prev), 32'd0);
         end
         prev = sample;
      end
      rd_b = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      checks_total  = 0;
      checks_passed = 0;
      rst_n_a = 1'b0;
      rst_n_b = 1'b0;
      {rd_a, wr_a, rd_b, wr_b} = 4'b0;
      adr_a = '0;
      in_a  = '0;
      adr_b = '0;
      in_b  = '0;
      repeat (3) @(negedge clk);
      checkOutput("reset_ready_a", 32'(ready_a), 32'd0);
      checkOutput("reset_out_a", out_a, 32'd0);
      checkOutput("reset_err_a", 32'(err_a), 32'd0);
      checkOutput("reset_ready_b", 32'(ready_b), 32'd0);
      rst_n_a = 1'b1;
      rst_n_b = 1'b1;
      @(negedge clk);

      $display("[TB] write then read back");
      applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

      $display("[TB] zero-wait held read");
      holdReadZeroWait();

      $display("[TB] simultaneous read and write");
      applyStimulus(1'b1, 1'b1, 32'h8, 32'h1234, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 32'h00001234, 1'b0);

      $display("[TB] address wrap-around");
      applyStimulus(1'b0, 1'b1, 32'h1000, 32'hA5A5A5A5, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

      $display("[TB] reset mid-transaction");
      applyStimulus(1'b0, 1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0);
      abortWriteInWait(32'h20, 32'h55);
      applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);
      readThenReset(32'h20, 32'h11111111);
      applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);

`ifdef MEM_MISALIGN_ERR_EN
      $display("[TB] misaligned write");
      applyStimulus(1'b0, 1'b1, 32'h22, 32'hFF, 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);
`endif

      repeat (4) @(negedge clk);
      checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
